// File: rtl/mips_core_pkg.sv
// Shared MIPS core types and default sizing for the rename path.
package mips_core_pkg;

    localparam int DEFAULT_ARCH_REGS = 32;
    localparam int DEFAULT_PHYS_REGS = 64;
    localparam int MIPS_ARCH_W       = $clog2(DEFAULT_ARCH_REGS);
    localparam int MIPS_PHYS_W       = $clog2(DEFAULT_PHYS_REGS);

    typedef logic [MIPS_ARCH_W-1:0] MipsReg;
    typedef logic [MIPS_PHYS_W-1:0] PhysReg;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins priority encoder; used to pick the next free physical register.
module priority_encoder #(
    parameter int NUM_OF_INPUTS = 64,
    parameter int IDX_W         = $clog2(NUM_OF_INPUTS)
) (
    input  logic [NUM_OF_INPUTS-1:0] req,
    output logic [IDX_W-1:0]         idx,
    output logic                     valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_OF_INPUTS - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rename_map_unit.sv
// Register rename unit: speculative and retirement map tables plus free-list
// bitmaps, one rename per cycle, commit-driven freeing and single-cycle flush.
module rename_map_unit
    import mips_core_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEFAULT_ARCH_REGS,
    parameter int NUM_PHYS_REGS = DEFAULT_PHYS_REGS,
    parameter int ARCH_W        = $clog2(NUM_ARCH_REGS),
    parameter int PHYS_W        = $clog2(NUM_PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren_valid,
    output logic              ren_ready,
    input  logic [ARCH_W-1:0] ren_rs,
    input  logic [ARCH_W-1:0] ren_rt,
    input  logic [ARCH_W-1:0] ren_rw,
    input  logic              ren_uses_rs,
    input  logic              ren_uses_rt,
    input  logic              ren_uses_rw,
    output logic              out_valid,
    output logic [PHYS_W-1:0] out_rs,
    output logic [PHYS_W-1:0] out_rt,
    output logic [PHYS_W-1:0] out_rw,
    output logic [PHYS_W-1:0] out_prev_rw,
    input  logic              commit_valid,
    input  logic [ARCH_W-1:0] commit_rw,
    input  logic [PHYS_W-1:0] commit_phys,
    input  logic [PHYS_W-1:0] commit_prev,
    input  logic              flush,
    output logic [PHYS_W:0]   free_count
);

    logic [PHYS_W-1:0]        spec_map     [NUM_ARCH_REGS];
    logic [PHYS_W-1:0]        spec_map_nxt [NUM_ARCH_REGS];
    logic [PHYS_W-1:0]        ret_map      [NUM_ARCH_REGS];
    logic [PHYS_W-1:0]        ret_map_nxt  [NUM_ARCH_REGS];
    logic [NUM_PHYS_REGS-1:0] free_bm, free_nxt;
    logic [NUM_PHYS_REGS-1:0] ret_free_bm, ret_free_nxt;
    logic [PHYS_W:0]          free_cnt_nxt;
    logic [PHYS_W-1:0]        alloc_idx;
    logic                     any_free;
    logic                     accept, alloc, commit_en;

    // Allocation looks only at the registered bitmap, so a register freed by a
    // commit this cycle cannot be handed out until the next cycle.
    priority_encoder #(
        .NUM_OF_INPUTS (NUM_PHYS_REGS),
        .IDX_W         (PHYS_W)
    ) u_alloc_enc (
        .req   (free_bm),
        .idx   (alloc_idx),
        .valid (any_free)
    );

    // Handshake: flush blocks renames; a real destination needs a free register.
    always_comb begin
        ren_ready = !flush && (!ren_uses_rw || (ren_rw == '0) || any_free);
        accept    = ren_valid && ren_ready;
        alloc     = accept && ren_uses_rw && (ren_rw != '0);
        commit_en = commit_valid && (commit_rw != '0);
    end

    // Next state: commit first, then allocation, then flush overrides the
    // speculative copy with the retirement copy (including this cycle's commit).
    always_comb begin
        spec_map_nxt = spec_map;
        ret_map_nxt  = ret_map;
        free_nxt     = free_bm;
        ret_free_nxt = ret_free_bm;
        if (commit_en) begin
            ret_map_nxt[commit_rw]    = commit_phys;
            ret_free_nxt[commit_phys] = 1'b0;
            ret_free_nxt[commit_prev] = 1'b1;
            free_nxt[commit_prev]     = 1'b1;
        end
        if (alloc) begin
            spec_map_nxt[ren_rw] = alloc_idx;
            free_nxt[alloc_idx]  = 1'b0;
        end
        if (flush) begin
            spec_map_nxt = ret_map_nxt;
            free_nxt     = ret_free_nxt;
        end
        free_cnt_nxt = '0;
        for (int i = 0; i < NUM_PHYS_REGS; i++) begin
            free_cnt_nxt = free_cnt_nxt + {{PHYS_W{1'b0}}, free_nxt[i]};
        end
    end

    // Map tables, bitmaps and the free counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                spec_map[i] <= PHYS_W'(i);
                ret_map[i]  <= PHYS_W'(i);
            end
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                free_bm[i]     <= (i >= NUM_ARCH_REGS);
                ret_free_bm[i] <= (i >= NUM_ARCH_REGS);
            end
            free_count <= (PHYS_W+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);
        end else begin
            spec_map    <= spec_map_nxt;
            ret_map     <= ret_map_nxt;
            free_bm     <= free_nxt;
            ret_free_bm <= ret_free_nxt;
            free_count  <= free_cnt_nxt;
        end
    end

    // Renamed outputs: one-cycle valid pulse, fields hold until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rw      <= '0;
            out_prev_rw <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_rs      <= ren_uses_rs ? spec_map[ren_rs] : '0;
                out_rt      <= ren_uses_rt ? spec_map[ren_rt] : '0;
                out_rw      <= alloc ? alloc_idx : '0;
                out_prev_rw <= alloc ? spec_map[ren_rw] : '0;
            end
        end
    end

endmodule

// File: tb/tb_rename_map_unit.sv
// Self-checking bench for rename_map_unit with a behavioural reference model
// and a scoreboard of expected renamed outputs.
module tb_rename_map_unit;
    import mips_core_pkg::*;

    typedef struct {
        PhysReg rs;
        PhysReg rt;
        PhysReg rw;
        PhysReg prev;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ren_valid = 1'b0, ren_ready;
    MipsReg     ren_rs = '0, ren_rt = '0, ren_rw = '0;
    logic       ren_uses_rs = 1'b0, ren_uses_rt = 1'b0, ren_uses_rw = 1'b0;
    logic       out_valid;
    PhysReg     out_rs, out_rt, out_rw, out_prev_rw;
    logic       commit_valid = 1'b0;
    MipsReg     commit_rw = '0;
    PhysReg     commit_phys = '0, commit_prev = '0;
    logic       flush = 1'b0;
    logic [6:0] free_count;

    int total = 0;
    int bad   = 0;

    PhysReg      m_spec [32];
    PhysReg      m_ret  [32];
    logic [63:0] m_free, m_rfree;
    exp_t        sb [$];

    always #5 clk = ~clk;

    rename_map_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ren_valid    (ren_valid),
        .ren_ready    (ren_ready),
        .ren_rs       (ren_rs),
        .ren_rt       (ren_rt),
        .ren_rw       (ren_rw),
        .ren_uses_rs  (ren_uses_rs),
        .ren_uses_rt  (ren_uses_rt),
        .ren_uses_rw  (ren_uses_rw),
        .out_valid    (out_valid),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rw       (out_rw),
        .out_prev_rw  (out_prev_rw),
        .commit_valid (commit_valid),
        .commit_rw    (commit_rw),
        .commit_phys  (commit_phys),
        .commit_prev  (commit_prev),
        .flush        (flush),
        .free_count   (free_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = PhysReg'(i);
            m_ret[i]  = PhysReg'(i);
        end
        m_free  = {32'hFFFF_FFFF, 32'h0};
        m_rfree = {32'hFFFF_FFFF, 32'h0};
        sb.delete();
    endtask

    // One cycle of stimulus: predict, drive, update model, score outputs.
    task automatic step(input logic v, input int rs, input int rt, input int rw,
                        input logic urs, input logic urt, input logic urw,
                        input logic cv, input int crw, input int cphys, input int cprev,
                        input logic fl);
        logic exp_ready, acc, needs;
        int   p;
        exp_t e, got;
        @(negedge clk);
        ren_valid = v; ren_rs = MipsReg'(rs); ren_rt = MipsReg'(rt); ren_rw = MipsReg'(rw);
        ren_uses_rs = urs; ren_uses_rt = urt; ren_uses_rw = urw;
        commit_valid = cv; commit_rw = MipsReg'(crw);
        commit_phys = PhysReg'(cphys); commit_prev = PhysReg'(cprev);
        flush = fl;
        #1;
        exp_ready = !fl && (!urw || rw == 0 || m_free != 64'h0);
        total++;
        if (ren_ready !== exp_ready) begin
            bad++;
            $display("FAIL ren_ready: got %b want %b (rw=%0d)", ren_ready, exp_ready, rw);
        end
        acc   = v && exp_ready;
        needs = urw && rw != 0;
        p = 0;
        for (int i = 63; i >= 0; i--) if (m_free[i]) p = i;
        if (acc) begin
            e.rs   = urs ? m_spec[rs] : '0;
            e.rt   = urt ? m_spec[rt] : '0;
            e.rw   = needs ? PhysReg'(p) : '0;
            e.prev = needs ? m_spec[rw] : '0;
            sb.push_back(e);
        end
        if (cv && crw != 0) begin
            m_ret[crw]     = PhysReg'(cphys);
            m_rfree[cphys] = 1'b0;
            m_rfree[cprev] = 1'b1;
            m_free[cprev]  = 1'b1;
        end
        if (acc && needs) begin
            m_spec[rw] = PhysReg'(p);
            m_free[p]  = 1'b0;
        end
        if (fl) begin
            m_spec = m_ret;
            m_free = m_rfree;
        end
        @(posedge clk);
        #1;
        ren_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0;
        total++;
        if (out_valid !== acc) begin
            bad++;
            $display("FAIL out_valid: got %b want %b", out_valid, acc);
        end
        if (out_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: out_valid with nothing expected");
            end else begin
                got = sb.pop_front();
                if (out_rs !== got.rs || out_rt !== got.rt || out_rw !== got.rw || out_prev_rw !== got.prev) begin
                    bad++;
                    $display("FAIL rename_out: got rs=%0d rt=%0d rw=%0d prev=%0d want rs=%0d rt=%0d rw=%0d prev=%0d",
                             out_rs, out_rt, out_rw, out_prev_rw, got.rs, got.rt, got.rw, got.prev);
                end
            end
        end
        total++;
        if (free_count !== 7'($countones(m_free))) begin
            bad++;
            $display("FAIL free_count: got %0d want %0d", free_count, $countones(m_free));
        end
    endtask

    // Convenience wrappers.
    task automatic ren(input int rs, input int rt, input int rw);
        step(1'b1, rs, rt, rw, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (out_valid !== 1'b0 || out_rw !== '0 || out_rs !== '0 || free_count !== 7'd32) begin
            bad++;
            $display("FAIL reset_state: out_valid=%b out_rs=%0d out_rw=%0d free_count=%0d want 0 0 0 32",
                     out_valid, out_rs, out_rw, free_count);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ren_uses_rw = 1'b1; ren_rw = 5'd3; #1;
        total++;
        if (ren_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", ren_ready);
        end
        ren_uses_rw = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        ren(2, 3, 1);
        total++;
        if (out_rs !== 6'd2 || out_rt !== 6'd3 || out_rw !== 6'd32 || out_prev_rw !== 6'd1 || free_count !== 7'd31) begin
            bad++;
            $display("FAIL basic: got rs=%0d rt=%0d rw=%0d prev=%0d fc=%0d want 2 3 32 1 31",
                     out_rs, out_rt, out_rw, out_prev_rw, free_count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i < 32; i++) ren(0, 0, i);
        ren(0, 0, 1);
        total++;
        if (free_count !== 7'd0 || out_rw !== 6'd63) begin
            bad++;
            $display("FAIL full_fill: fc=%0d rw=%0d want 0 63", free_count, out_rw);
        end
        ren(1, 0, 2);
        total++;
        if (out_valid !== 1'b0 || out_rw !== 6'd63 || free_count !== 7'd0) begin
            bad++;
            $display("FAIL full_stall: valid=%b rw=%0d fc=%0d want 0 63 0", out_valid, out_rw, free_count);
        end
        step(1'b1, 2, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_rs !== 6'd33 || out_rw !== 6'd0) begin
            bad++;
            $display("FAIL full_nodest: valid=%b rs=%0d rw=%0d want 1 33 0", out_valid, out_rs, out_rw);
        end
    endtask

    task automatic test_commit_free();
        do_reset();
        ren(0, 0, 4);
        ren(0, 0, 4);
        step(1'b1, 0, 0, 5, 1'b0, 1'b0, 1'b1, 1'b1, 4, 32, 4, 1'b0);
        total++;
        if (out_rw !== 6'd34) begin
            bad++;
            $display("FAIL commit_same_cycle: rw=%0d want 34", out_rw);
        end
        ren(0, 0, 6);
        total++;
        if (out_rw !== 6'd4) begin
            bad++;
            $display("FAIL commit_next_cycle: rw=%0d want 4", out_rw);
        end
    endtask

    task automatic test_flush_restore();
        do_reset();
        ren(0, 0, 7);
        step(1'b1, 0, 0, 7, 1'b0, 1'b0, 1'b1, 1'b1, 7, 32, 7, 1'b0);
        total++;
        if (out_rw !== 6'd33 || out_prev_rw !== 6'd32) begin
            bad++;
            $display("FAIL flush_pre: rw=%0d prev=%0d want 33 32", out_rw, out_prev_rw);
        end
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        total++;
        if (free_count !== 7'd32) begin
            bad++;
            $display("FAIL flush_count: fc=%0d want 32", free_count);
        end
        ren(7, 0, 7);
        total++;
        if (out_prev_rw !== 6'd32 || out_rs !== 6'd32 || out_rw !== 6'd7) begin
            bad++;
            $display("FAIL flush_after: prev=%0d rs=%0d rw=%0d want 32 32 7", out_prev_rw, out_rs, out_rw);
        end
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        ren(0, 0, 9);
        step(1'b1, 0, 0, 10, 1'b0, 1'b0, 1'b1, 1'b1, 9, 32, 9, 1'b1);
        total++;
        if (out_valid !== 1'b0 || free_count !== 7'd32) begin
            bad++;
            $display("FAIL flush_drop: valid=%b fc=%0d want 0 32", out_valid, free_count);
        end
        step(1'b1, 9, 10, 3, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        total++;
        if (out_rs !== 6'd32 || out_rt !== 6'd10 || out_rw !== 6'd9 || out_prev_rw !== 6'd3) begin
            bad++;
            $display("FAIL flush_commit: rs=%0d rt=%0d rw=%0d prev=%0d want 32 10 9 3",
                     out_rs, out_rt, out_rw, out_prev_rw);
        end
    endtask

    task automatic test_zero_dest();
        do_reset();
        step(1'b1, 5, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_rw !== 6'd0 || out_prev_rw !== 6'd0 || out_rs !== 6'd5 || free_count !== 7'd32) begin
            bad++;
            $display("FAIL zero_dest: valid=%b rw=%0d prev=%0d rs=%0d fc=%0d want 1 0 0 5 32",
                     out_valid, out_rw, out_prev_rw, out_rs, free_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ren(5, 5, 5);
        total++;
        if (out_rs !== 6'd5 || out_rw !== 6'd32) begin
            bad++;
            $display("FAIL self_dep: rs=%0d rw=%0d want 5 32", out_rs, out_rw);
        end
        ren(5, 0, 6);
        total++;
        if (out_rs !== 6'd32 || out_rw !== 6'd33) begin
            bad++;
            $display("FAIL raw_dep: rs=%0d rw=%0d want 32 33", out_rs, out_rw);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        ren(1, 2, 3);
        ren(4, 5, 6);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        total++;
        if (out_valid !== 1'b0 || out_rw !== 6'd0 || free_count !== 7'd32) begin
            bad++;
            $display("FAIL mid_reset: valid=%b rw=%0d fc=%0d want 0 0 32", out_valid, out_rw, free_count);
        end
        @(negedge clk);
        rst = 1'b0;
        ren(0, 0, 3);
        total++;
        if (out_prev_rw !== 6'd3 || out_rw !== 6'd32) begin
            bad++;
            $display("FAIL mid_reset_after: prev=%0d rw=%0d want 3 32", out_prev_rw, out_rw);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 120; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), 1'($urandom), 1'($urandom), $urandom_range(0, 4) != 0,
                 1'b0, 0, 0, 0, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_commit_free();
        test_flush_restore();
        test_flush_same_cycle();
        test_zero_dest();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_map_unit.md
# rename_map_unit

Parametrised register-rename unit for the out-of-order MIPS core, sitting between decode and dispatch. It holds a speculative map table, a retirement map table and a free-list bitmap. Each cycle it renames one instruction's sources and destination, frees physical registers on commit, and restores speculative state from the retirement map in one cycle on a pipeline flush. Unlike the earlier combinational map table, all state is clocked, allocation is back-pressured, and recovery is supported.

## Interface
Parameters:
- NUM_ARCH_REGS, 32, number of architectural registers; register 0 is hard-wired zero.
- NUM_PHYS_REGS, 64, number of physical registers; must be greater than NUM_ARCH_REGS.
- ARCH_W, $clog2(NUM_ARCH_REGS), architectural register index width.
- PHYS_W, $clog2(NUM_PHYS_REGS), physical register index width.

Ports:
- clk  in  1  clock; one clock domain, all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ren_valid  in  1  decode presents an instruction.
- ren_ready  out  1  unit can accept the instruction this cycle.
- ren_rs, ren_rt, ren_rw  in  ARCH_W each  architectural source and destination registers.
- ren_uses_rs, ren_uses_rt, ren_uses_rw  in  1 each  operand-use flags.
- out_valid  out  1  renamed result valid; pulses for one cycle.
- out_rs, out_rt, out_rw  out  PHYS_W each  physical source and destination registers.
- out_prev_rw  out  PHYS_W  previous mapping of ren_rw, sent to the active list.
- commit_valid  in  1  active list retires an instruction with a destination.
- commit_rw  in  ARCH_W  architectural destination being retired.
- commit_phys  in  PHYS_W  physical register being made architectural.
- commit_prev  in  PHYS_W  physical register to free.
- flush  in  1  restore speculative state from retirement state.
- free_count  out  PHYS_W+1  number of free physical registers.

## Operation
- State:
  - spec_map[NUM_ARCH_REGS] and ret_map[NUM_ARCH_REGS], each PHYS_W wide.
  - free_bm[NUM_PHYS_REGS] for speculative state and ret_free_bm[NUM_PHYS_REGS] for retirement state; 1 means free.
- Reset values:
  - Both maps: map[i] = i.
  - Both bitmaps: bits 0..NUM_ARCH_REGS-1 = 0, all other bits = 1.
  - out_valid = 0; all out_* = 0; free_count = NUM_PHYS_REGS-NUM_ARCH_REGS.
- Accepting an instruction:
  - ren_ready = !flush && (!ren_uses_rw || ren_rw==0 || free_bm != 0).
  - An instruction is accepted when ren_valid && ren_ready.
- On accept:
  - out_rs = ren_uses_rs ? spec_map[ren_rs] : 0; out_rt is formed the same way.
  - Sources read the mapping that exists before this instruction's own destination is renamed. If rs == rw, out_rs is the old mapping.
  - If ren_uses_rw and ren_rw != 0: the lowest-index free bit P is allocated, out_rw = P, out_prev_rw = spec_map[ren_rw], spec_map[ren_rw] <= P, free_bm[P] <= 0.
  - Otherwise out_rw = 0, out_prev_rw = 0, and no state changes.
- Commit:
  - ret_map[commit_rw] <= commit_phys; ret_free_bm[commit_phys] <= 0.
  - ret_free_bm[commit_prev] <= 1 and free_bm[commit_prev] <= 1.
  - Commit is ignored when commit_rw == 0.
- Flush:
  - spec_map <= ret_map and free_bm <= ret_free_bm.
  - The values used include any commit presented in the same cycle.
  - Any rename in that cycle is dropped; out_valid = 0 in the following cycle.
- Simultaneous events:
  - A register freed by commit cannot be allocated in the same cycle; it becomes allocatable from the next cycle.
  - Commit and rename in the same cycle both take effect.
  - Flush has priority over rename.
- Full condition: when free_bm == 0 and the instruction needs a destination, ren_ready = 0 and no state changes.
- Reset mid-operation: all state returns to the reset values immediately.

## Timing
- ren_ready is combinational from state, flush and the ren_* inputs.
- Renamed outputs are registered. out_valid and out_* appear in the cycle after the accept and hold their values until the next accept. out_valid is high for exactly one cycle per accepted instruction.
- Map, bitmap and free_count updates are visible in the cycle after the triggering edge.
- Back-to-back renames with a dependency (I1 writes r5, I2 reads r5): I2 sees I1's allocated register, because spec_map updates at the edge between them.
- free_count is a registered popcount of free_bm and reflects the current state.

## Structure
- Shared package mips_core_pkg holds:
  - the NUM_ARCH_REGS and NUM_PHYS_REGS defaults;
  - typedef PhysReg, logic [PHYS_W-1:0];
  - the existing MipsReg type for architectural indices.
- Sub-module: reuse priority_encoder (NUM_OF_INPUTS = NUM_PHYS_REGS, lowest index wins) for allocation.
- Popcount is inline.

## Test plan
- Reset, then rename r1 <- r2, r3 -> out_rs=2, out_rt=3, out_rw=32, out_prev_rw=1, free_count 32->31.
- 32 consecutive renames of r1..r31 plus r1, then a 33rd -> ren_ready=0 on the 33rd; free_count=0; state unchanged while stalled.
- Rename r4 twice (gets 32, then 33), then commit (r4, phys 32, prev 4) -> phys 4 allocatable the cycle after commit, not the same cycle.
- Rename r7 -> 32, commit it, rename r7 -> 33, then flush -> spec_map[7]=32; phys 33 free again; a subsequent rename of r7 reads prev 32.
- Flush, commit and rename in the same cycle -> rename dropped (out_valid=0 next cycle); commit reflected in the restored spec_map.
- Rename with ren_rw=0 and uses_rw=1 -> out_rw=0, no allocation, free_count unchanged.
